// File: rtl/lane_phase_sequencer_pkg.sv
// traffic_pkg: phase states, light field encodings and lane legality helpers shared by the sequencer.
package traffic_pkg;
    typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} phase_t;
    localparam logic [1:0] LIGHT_RED = 2'b00, LIGHT_YELLOW = 2'b01, LIGHT_GREEN = 2'b11;
    localparam logic [7:0] LANE_NS = 8'b00110011, LANE_EW = 8'b11001100;
    function automatic logic lane_is_legal(input logic [7:0] lane);
        return lane == LANE_NS || lane == LANE_EW;
    endfunction
    function automatic logic [7:0] yellowOf(input logic [7:0] l);
        logic [7:0] y;
        for (int i = 0; i < 4; i++) y[2*i+:2] = l[2*i+:2] == LIGHT_GREEN ? LIGHT_YELLOW : l[2*i+:2];
        return y;
    endfunction
endpackage

// File: rtl/lane_phase_sequencer_if.sv
// lane_phase_sequencer_if: lane request in, light drive and status out.
interface lane_phase_sequencer_if;
    logic       tick;
    logic [7:0] laneRequest;
    logic [6:0] loadTime;
    logic [7:0] lights;
    logic       phaseAck;
    logic [6:0] timeRemaining;
    logic       fault;
    modport master (output tick, laneRequest, loadTime, input lights, phaseAck, timeRemaining, fault);
    modport slave (input tick, laneRequest, loadTime, output lights, phaseAck, timeRemaining, fault);
endinterface

// File: rtl/lane_phase_sequencer_phase_counter.sv
// phase_counter: tick-enabled 7-bit down-counter with synchronous load; expire flags the last tick.
module phase_counter #(
    parameter logic [6:0] INIT = 7'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] loadVal,
    output logic [6:0] count,
    output logic       expire
);
    assign expire = tick && count == 7'd1;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= INIT;
        else if (load) count <= loadVal;
        else if (tick) count <= count - 7'd1;
endmodule

// File: rtl/lane_phase_sequencer.sv
// lane_phase_sequencer: green -> yellow -> all-red sequencing of the requested lane pattern.
module lane_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1
) (
    input logic clk,
    input logic rst,
    lane_phase_sequencer_if.slave bus
);
    phase_t     state;
    logic [7:0] lights;
    logic       phaseAck, fault, expire, legal, same;
    logic [6:0] loadClamp, nextTime;
    assign legal = lane_is_legal(bus.laneRequest);
    assign same = bus.laneRequest == lights;
    assign loadClamp = bus.loadTime == 7'd0 ? 7'd1 : bus.loadTime;
    // Reload value for whichever state the expiry leads into.
    assign nextTime = state == YELLOW ? 7'(ALLRED_TIME) :
                      state == GREEN ? (same ? loadClamp : 7'(YELLOW_TIME)) :
                      (legal ? loadClamp : 7'(ALLRED_TIME));
    phase_counter #(.INIT(7'(ALLRED_TIME))) u_cnt (
        .clk(clk), .rst(rst), .tick(bus.tick), .load(expire),
        .loadVal(nextTime), .count(bus.timeRemaining), .expire(expire)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ALLRED;
            lights <= {4{LIGHT_RED}};
            phaseAck <= 1'b0;
            fault <= 1'b0;
        end else begin
            phaseAck <= expire && state != YELLOW;
            if (expire)
                case (state)
                    ALLRED: if (legal) begin
                        state <= GREEN;
                        lights <= bus.laneRequest;
                    end else fault <= 1'b1;
                    GREEN: if (!same) begin
                        state <= YELLOW;
                        lights <= yellowOf(lights);
                    end
                    default: begin
                        state <= ALLRED;
                        lights <= {4{LIGHT_RED}};
                    end
                endcase
        end
    end
    assign bus.lights = lights;
    assign bus.phaseAck = phaseAck;
    assign bus.fault = fault;
endmodule

// File: tb/tb_lane_phase_sequencer.sv
// tb_lane_phase_sequencer: directed scenarios with hand-computed light/timer/ack/fault sequences.
module tb_lane_phase_sequencer;
    logic clk = 0, rst = 1;
    int total = 0, bad = 0;
    lane_phase_sequencer_if bus();
    lane_phase_sequencer #(.YELLOW_TIME(3), .ALLRED_TIME(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0] bL [9] = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h11, 8'h11, 8'h11, 8'h00};
    logic [6:0] bT [9] = '{7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd3, 7'd2, 7'd1, 7'd1};
    logic       bA [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] zL [8] = '{8'h33, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h33};
    logic [6:0] zT [8] = '{7'd1, 7'd3, 7'd2, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1};
    logic       zA [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       zF [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    function automatic logic [16:0] obs();
        return {bus.lights, bus.timeRemaining, bus.phaseAck, bus.fault};
    endfunction

    function automatic logic isGreen(input logic [7:0] l);
        return l == 8'h33 || l == 8'hCC;
    endfunction

    task automatic doTick;
        @(negedge clk);
        bus.tick = 1;
        @(posedge clk);
        #1;
        bus.tick = 0;
    endtask

    task automatic doReset(input logic [7:0] req, input logic [6:0] lt);
        @(negedge clk);
        rst = 0;
        bus.laneRequest = req;
        bus.loadTime = lt;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset;
        bus.tick = 0;
        bus.laneRequest = 8'h33;
        bus.loadTime = 7'd5;
        #2 rst = 0;
        #1;
        total++;
        if (obs() !== {8'h00, 7'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async obs=%h exp=%h", obs(), {8'h00, 7'd1, 1'b0, 1'b0});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== {8'h00, 7'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold obs=%h exp=%h", obs(), {8'h00, 7'd1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 9; i++) begin
            doTick();
            total++;
            if (obs() !== {bL[i], bT[i], bA[i], 1'b0}) begin
                bad++;
                $display("FAIL basic_tick%0d obs=%h exp=%h", i + 1, obs(), {bL[i], bT[i], bA[i], 1'b0});
            end
            if (i == 0) bus.laneRequest = 8'hCC;
        end
    endtask

    task automatic test_alternate;
        logic [7:0] prevL, lastGreen, l;
        int greens;
        prevL = 8'h00;
        lastGreen = 8'h33;
        greens = 0;
        bus.loadTime = 7'd2;
        for (int i = 0; i < 40; i++) begin
            doTick();
            l = bus.lights;
            total++;
            if ((|{l[5:4], l[1:0]}) && (|{l[7:6], l[3:2]})) begin
                bad++;
                $display("FAIL alt_both_axes tick%0d lights=%h exp=one axis", i, l);
            end
            if (isGreen(l) && !isGreen(prevL)) begin
                greens++;
                total++;
                if (prevL !== 8'h00 || l === lastGreen) begin
                    bad++;
                    $display("FAIL alt_green_entry tick%0d prev=%h lights=%h exp prev=00 and not %h", i, prevL, l, lastGreen);
                end
                lastGreen = l;
            end
            if (isGreen(prevL) && l != prevL) begin
                total++;
                if (l === 8'h00) begin
                    bad++;
                    $display("FAIL alt_green_to_red tick%0d prev=%h lights=%h exp yellow", i, prevL, l);
                end
            end
            if (bus.phaseAck && isGreen(l)) bus.laneRequest = ~l;
            prevL = l;
        end
        total++;
        if (greens < 4) begin
            bad++;
            $display("FAIL alt_green_count got=%0d exp>=4", greens);
        end
    endtask

    task automatic test_hold;
        doReset(8'hCC, 7'd4);
        doTick();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) doTick();
            total++;
            if (obs() !== {8'hCC, 7'(4 - i % 4), i % 4 == 0, 1'b0}) begin
                bad++;
                $display("FAIL hold_tick%0d obs=%h exp=%h", i, obs(), {8'hCC, 7'(4 - i % 4), i % 4 == 0, 1'b0});
            end
        end
    endtask

    task automatic test_zero_fault;
        doReset(8'h33, 7'd0);
        for (int i = 0; i < 8; i++) begin
            doTick();
            total++;
            if (obs() !== {zL[i], zT[i], zA[i], zF[i]}) begin
                bad++;
                $display("FAIL zero_fault_tick%0d obs=%h exp=%h", i + 1, obs(), {zL[i], zT[i], zA[i], zF[i]});
            end
            if (i == 0) bus.laneRequest = 8'hCC;
            if (i == 4) bus.laneRequest = 8'hFF;
            if (i == 6) bus.laneRequest = 8'h33;
        end
    endtask

    task automatic test_async_reset;
        #2 rst = 0;
        #1;
        total++;
        if (obs() !== {8'h00, 7'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset obs=%h exp=%h", obs(), {8'h00, 7'd1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_tick_hold;
        doReset(8'h33, 7'd5);
        doTick();
        bus.laneRequest = 8'hCC;
        repeat (6) doTick();
        total++;
        if (obs() !== {8'h11, 7'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_yellow_entry obs=%h exp=%h", obs(), {8'h11, 7'd2, 1'b0, 1'b0});
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (obs() !== {8'h11, 7'd2, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL tick_hold_cyc%0d obs=%h exp=%h", i, obs(), {8'h11, 7'd2, 1'b0, 1'b0});
            end
        end
        doTick();
        total++;
        if (obs() !== {8'h11, 7'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_resume obs=%h exp=%h", obs(), {8'h11, 7'd1, 1'b0, 1'b0});
        end
        doTick();
        total++;
        if (obs() !== {8'h00, 7'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_allred obs=%h exp=%h", obs(), {8'h00, 7'd1, 1'b0, 1'b0});
        end
        doTick();
        total++;
        if (obs() !== {8'hCC, 7'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL hold_next_green obs=%h exp=%h", obs(), {8'hCC, 7'd5, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_hold();
        test_zero_fault();
        test_async_reset();
        test_tick_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
